anim_controller: RTL

Parametrised animation controller for the VGA pattern pipeline. It generalises the fixed six-speed pause/resume control into a configurable block:

- N speed levels, pause/resume plus single-frame step.
- A frame-locked phase accumulator.
- Manual and automatic pattern cycling.

It sits between the board inputs and the VGA timing generator on one side, and the pattern generators on the other. All animation state changes only on frame boundaries, so no frame tears.

---
 rtl/anim_controller.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/anim_controller.sv
// Frame-locked animation controller: speed latch, pause/resume/step FSM,
// phase accumulator and manual/automatic pattern cycling for the VGA pattern pipeline.
module anim_controller #(
  parameter int NUM_SPEEDS       = 6,
  parameter int PHASE_W          = 10,
  parameter int NUM_PATTERNS     = 4,
  parameter int AUTO_FRAMES      = 256,
  parameter int SYNC_STAGES      = 2,
  parameter int VSYNC_ACTIVE_LOW = 1,
  localparam int SW  = $clog2(NUM_SPEEDS + 1),
  localparam int PSW = $clog2(NUM_PATTERNS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vsync,
  input  logic                  pause,
  input  logic                  resume,
  input  logic                  step,
  input  logic                  next_pattern,
  input  logic                  auto_en,
  input  logic [NUM_SPEEDS-2:0] speed_req,
  output logic                  paused,
  output logic [SW-1:0]         step_size,
  output logic [PHASE_W-1:0]    phase,
  output logic [PSW-1:0]        pattern_sel,
  output logic                  frame_tick
);

  localparam int NIN = NUM_SPEEDS + 5;
  localparam int CW  = $clog2(AUTO_FRAMES);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_PAUSE = 2'd1;
  localparam logic [1:0] ST_STEP  = 2'd2;

  logic [NIN-1:0]         sync_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] fill_q;
  logic [NIN-1:0]         s;
  logic [4:0]             lvl, prev_q, armed_q, edge_v;
  logic                   ftick, pause_e, resume_e, step_e, next_e, auto_s;
  logic [NUM_SPEEDS-2:0]  speed_s;
  logic [SW-1:0]          speed_enc;
  logic [1:0]             state_q, state_d;
  logic                   pend_q;
  logic [CW-1:0]          cnt_q;
  logic                   run_st, advance_ok, manual_adv, auto_adv, adv;
  logic [PSW-1:0]         pat_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      fill_q <= '0;
    end else begin
      sync_q[0] <= {speed_req, auto_en, next_pattern, step, resume, pause, vsync};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1];
  assign auto_s  = s[5];
  assign speed_s = s[NIN-1:6];

  // vsync is normalised so every edge source is a rising edge. An edge only
  // counts once the source has been seen low after the synchroniser filled,
  // so an input held high across reset never fires.
  assign lvl      = {s[4], s[3], s[2], s[1], (VSYNC_ACTIVE_LOW != 0) ? ~s[0] : s[0]};
  assign edge_v   = lvl & ~prev_q & armed_q;
  assign ftick    = edge_v[0];
  assign pause_e  = edge_v[1];
  assign resume_e = edge_v[2];
  assign step_e   = edge_v[3];
  assign next_e   = edge_v[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q  <= '0;
      armed_q <= '0;
    end else begin
      prev_q  <= lvl;
      armed_q <= armed_q | (~lvl & {5{fill_q[SYNC_STAGES-1]}});
    end
  end

  always_comb begin
    speed_enc = SW'(1);
    for (int unsigned i = 0; i < NUM_SPEEDS - 1; i++)
      if (speed_s[i]) speed_enc = SW'(i + 2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (pause_e) state_d = ST_PAUSE;
      ST_PAUSE: if (!pause_e) begin
                  if (resume_e)    state_d = ST_RUN;
                  else if (step_e) state_d = ST_STEP;
                end
      ST_STEP:  if (!pause_e) begin
                  if (resume_e)   state_d = ST_RUN;
                  else if (ftick) state_d = ST_PAUSE;
                end
      default:  state_d = ST_RUN;
    endcase
  end

  assign run_st     = (state_q == ST_RUN);
  assign advance_ok = run_st || (state_q == ST_STEP);
  assign manual_adv = ftick && pend_q;
  assign auto_adv   = ftick && auto_s && run_st && (cnt_q == CW'(AUTO_FRAMES - 1));
  assign adv        = manual_adv || auto_adv;
  assign pat_next   = (pattern_sel == PSW'(NUM_PATTERNS - 1)) ? '0 : pattern_sel + PSW'(1);
  assign paused     = (state_q != ST_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      frame_tick  <= 1'b0;
      step_size   <= SW'(1);
      phase       <= '0;
      pattern_sel <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q    <= state_d;
      frame_tick <= ftick;
      if (ftick) step_size <= speed_enc;

      // A pattern change restarts the animation, taking precedence over the step.
      if (adv) begin
        pattern_sel <= pat_next;
        phase       <= '0;
      end else if (ftick && advance_ok) begin
        phase <= phase + PHASE_W'(step_size);
      end

      if (next_e)     pend_q <= 1'b1;
      else if (ftick) pend_q <= 1'b0;

      if (!auto_s || adv)      cnt_q <= '0;
      else if (ftick && run_st) cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule
